// File: rtl/mem_fetch_unit_pkg.sv
// Shared encodings for the memory-read stage and the CPU control FSM.
// Address-source codes, fetch state encoding and the halt instruction.
package mem_fetch_unit_pkg;

    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned TIMEOUT_DEF = 255;

    // memAddr codes as driven by the controller; 2'b11 reads address 0
    localparam logic [1:0] READ_FROM_PC  = 2'b00;
    localparam logic [1:0] READ_FROM_MEM = 2'b01;
    localparam logic [1:0] READ_FROM_C   = 2'b10;

    // Top nibble 0011 routes the controller to its HALT path
    localparam logic [15:0] CTRL_HALT_OPCODE = 16'h3000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait counter for the REQ state: cleared on access start, counts while enabled,
// and flags the terminal count TIMEOUT-1.
module mem_wait_timer
    import mem_fetch_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_c
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tc_c = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_fetch_unit.sv
// Memory-read stage: services opcode/operand read strobes with a req/ack
// handshake, stalls the controller until done, and turns a hung bus into HALT.
module mem_fetch_unit
    import mem_fetch_unit_pkg::*;
#(
    parameter int unsigned       DATA_W      = DATA_W_DEF,
    parameter int unsigned       ADDR_W      = ADDR_W_DEF,
    parameter int unsigned       TIMEOUT     = TIMEOUT_DEF,
    parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(CTRL_HALT_OPCODE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        memAddr,
    input  logic              saveOpcode,
    input  logic              saveMem,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] regC,
    output logic [DATA_W-1:0] opcode,
    output logic [DATA_W-1:0] memValue,
    output logic              stall,
    output logic              busError,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    fetch_state_t      state_q;
    logic              dest_opc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] opcode_q;
    logic [DATA_W-1:0] memval_q;
    logic              err_q;
    logic              req_q;

    logic              strobe;
    logic              start;
    logic              timeout;
    logic [ADDR_W-1:0] sel_addr;

    assign strobe = saveOpcode | saveMem;
    assign start  = (state_q == IDLE) && strobe;

    // Indirect reads use memValue as it stands when the access starts
    always_comb begin
        sel_addr = '0;
        case (memAddr)
            READ_FROM_PC:  sel_addr = pc;
            READ_FROM_MEM: sel_addr = ADDR_W'(memval_q);
            READ_FROM_C:   sel_addr = ADDR_W'(regC);
            default:       sel_addr = '0;
        endcase
    end

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start),
        .en_i  (state_q == REQ),
        .tc_c  (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dest_opc_q <= 1'b0;
            addr_q     <= '0;
            opcode_q   <= '0;
            memval_q   <= '0;
            err_q      <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (strobe) begin
                        addr_q     <= sel_addr;
                        dest_opc_q <= saveOpcode;
                        req_q      <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    // An ack on the terminal-count cycle still completes cleanly
                    if (mem_ack) begin
                        if (dest_opc_q) opcode_q <= mem_rdata;
                        else            memval_q <= mem_rdata;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (timeout) begin
                        if (dest_opc_q) opcode_q <= HALT_OPCODE;
                        else            memval_q <= '0;
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall    = start || (state_q == REQ);
    assign opcode   = opcode_q;
    assign memValue = memval_q;
    assign busError = err_q;
    assign mem_req  = req_q;
    assign mem_addr = addr_q;

endmodule

// File: doc/mem_fetch_unit.md
Name: mem_fetch_unit

Overview:
- Memory-read stage directly upstream of the CPU control FSM.
- Services the controller's read strobes (saveOpcode = instruction fetch, saveMem = operand fetch).
- Selects the read address from the controller's memAddr code and runs a req/ack handshake to external memory.
- Holds the instruction register (opcode) and internal value register (memValue), and stalls the controller until each read completes.
- A bounded-wait timer converts a hung bus into a controller halt.

Parameters:
- DATA_W, 16, memory data and register width.
- ADDR_W, 16, memory address width.
- TIMEOUT, 255, maximum REQ-state cycles without mem_ack before a bus error.
- HALT_OPCODE, 16'h3000, value forced into opcode on timeout; its top nibble 0011 decodes to the controller's HALT path.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- memAddr  in  2  address source: 00 PC, 01 memValue (indirect), 10 regC, 11 reserved (address 0)
- saveOpcode  in  1  controller requests a read into opcode
- saveMem  in  1  controller requests a read into memValue
- pc  in  ADDR_W  current program counter
- regC  in  DATA_W  C register contents
- opcode  out  DATA_W  instruction register
- memValue  out  DATA_W  internal value register
- stall  out  1  combinational; 1 = controller must hold its state and suppress enPC/enA/enB/enC/saveOpcode/saveMem effects
- busError  out  1  sticky timeout flag
- mem_req  out  1  read request to memory
- mem_addr  out  ADDR_W  read address, stable while mem_req=1
- mem_ack  in  1  memory read complete, mem_rdata valid this cycle
- mem_rdata  in  DATA_W  read data

Behaviour:
- Reset (rst=1 at posedge):
  - State IDLE; opcode, memValue, mem_addr, waitCnt = 0; mem_req = 0; busError = 0.
  - Reset during REQ drops mem_req the next cycle. A later mem_ack is ignored.
- State IDLE:
  - If saveOpcode|saveMem: stall=1 this cycle. Capture the selected address into mem_addr; capture the destination (opcode has priority if both strobes are high); clear waitCnt; go to REQ.
  - Otherwise stall=0.
- State REQ:
  - mem_req=1, stall=1, waitCnt increments each cycle.
  - If mem_ack: write mem_rdata to the captured destination register and go to DONE.
  - Else if waitCnt==TIMEOUT-1: opcode destination gets HALT_OPCODE, memValue destination gets 0. Set busError and go to DONE.
  - If mem_ack arrives on the timeout cycle, ack wins and there is no error.
- State DONE:
  - stall=0, mem_req=0. New data is visible on opcode/memValue and the controller advances at this edge.
  - Strobes are ignored this cycle (they are the held strobes of the completed access). Next state is IDLE.
- mem_ack outside REQ is ignored.
- mem_req is a registered state decode; the earliest ack is therefore one cycle after the strobe is seen.
- Zero-wait memory gives 3 cycles per access: IDLE-detect, REQ+ack, DONE. Each wait cycle adds 1.
- mem_addr is held constant from REQ entry until the next IDLE capture.
- memAddr=01 uses the memValue value as it stands at capture time.
- busError clears only on rst. Later accesses proceed normally after an error.
- Only opcode and memValue are ever written by this block.

Decomposition:
- Shared package:
  - memAddr encodings (READ_FROM_PC=2'b00, READ_FROM_MEM=2'b01, READ_FROM_C=2'b10).
  - State encodings IDLE/REQ/DONE.
  - HALT_OPCODE.
  - These encodings are the ones used by the controller.
- One sub-module: mem_wait_timer, a clear/enable/terminal-count counter parameterised by TIMEOUT, used for the REQ wait.

Test Plan:
- Reset, then saveOpcode=1, memAddr=00, pc=16'h0040, memory acks the cycle after mem_req with 16'h0A2B:
  - mem_addr=16'h0040; stall high for exactly 2 cycles.
  - opcode=16'h0A2B in the DONE cycle; busError=0.
- saveMem=1, memAddr=10, regC=16'h1234, ack after 5 wait cycles with 16'hBEEF:
  - stall high 7 cycles; memValue=16'hBEEF; opcode unchanged.
- saveOpcode and saveMem both high, memAddr=00, data 16'h5555:
  - opcode=16'h5555; memValue unchanged.
- No ack, TIMEOUT=4:
  - mem_req high 4 cycles; opcode=16'h3000; busError=1 and stays 1.
  - A subsequent fetch with ack loads its data normally.
- Ack asserted on the 4th REQ cycle, TIMEOUT=4, data 16'h0001:
  - opcode=16'h0001; busError=0.
- rst asserted during REQ, then mem_ack pulsed 2 cycles later:
  - mem_req=0 the cycle after rst.
  - opcode stays 0; the late ack has no effect; state IDLE.
